// File: rtl/rgb_frame_ctrl.sv
// RGB frame controller: pops pixel/marker words from a FIFO and hands
// them to the serial output stage while tracking LED and frame counts.
module rgb_frame_ctrl #(
  parameter int DATA_SIZE = 32,
  parameter int MAX_LEDS  = 256,
  parameter int CNT_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_enable,
  input  logic                 in_rd_fifo_empty,
  input  logic [DATA_SIZE-1:0] in_rd_fifo_data,
  output logic                 out_rd_fifo_en,
  output logic [DATA_SIZE-1:0] out_word,
  output logic                 out_valid,
  input  logic                 in_ready,
  output logic                 out_frame_done,
  output logic [CNT_W-1:0]     out_led_count,
  output logic [15:0]          out_frame_count,
  output logic                 out_overflow
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LEDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_OFFER,
    S_DROP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DATA_SIZE-1:0] r_word;
  logic                 r_marker;
  logic                 r_frame_done;
  logic [CNT_W-1:0]     r_led;
  logic [15:0]          r_frames;
  logic                 r_ovf;

  logic w_is_marker;
  logic w_full;
  logic w_accept;

  // Any set bit above the 24-bit RGB payload marks end of frame
  assign w_is_marker = |in_rd_fifo_data[DATA_SIZE-1:24];
  assign w_full      = (r_led == MAX_C);
  assign w_accept    = (r_state == S_OFFER) && in_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_enable && !in_rd_fifo_empty)
          w_next = S_POP;
      end
      S_POP:  w_next = S_LOAD;
      S_LOAD: begin
        if (!w_is_marker && w_full)
          w_next = S_DROP;
        else
          w_next = S_OFFER;
      end
      S_OFFER: begin
        if (in_ready)
          w_next = S_IDLE;
      end
      S_DROP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_marker     <= 1'b0;
      r_frame_done <= 1'b0;
      r_led        <= '0;
      r_frames     <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= w_accept && r_marker;
      if (r_state == S_LOAD) begin
        r_word   <= in_rd_fifo_data;
        r_marker <= w_is_marker;
        if (!w_is_marker && w_full)
          r_ovf <= 1'b1;
      end
      if (w_accept) begin
        if (r_marker) begin
          r_led    <= '0;
          r_frames <= r_frames + 16'd1;
        end else begin
          r_led <= r_led + 1'b1;
        end
      end
    end
  end

  assign out_rd_fifo_en  = (r_state == S_POP);
  assign out_valid       = (r_state == S_OFFER);
  assign out_word        = r_word;
  assign out_frame_done  = r_frame_done;
  assign out_led_count   = r_led;
  assign out_frame_count = r_frames;
  assign out_overflow    = r_ovf;

endmodule

// File: tb/tb_rgb_frame_ctrl.sv
// Scoreboard bench for rgb_frame_ctrl with a behavioural FIFO model
// and directed pixel/marker sequences.
module tb_rgb_frame_ctrl;

  localparam int DW = 32;
  localparam int ML = 4;
  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_enable;
  logic          in_rd_fifo_empty = 1'b1;
  logic [DW-1:0] in_rd_fifo_data = '0;
  logic          out_rd_fifo_en;
  logic [DW-1:0] out_word;
  logic          out_valid;
  logic          in_ready;
  logic          out_frame_done;
  logic [CW-1:0] out_led_count;
  logic [15:0]   out_frame_count;
  logic          out_overflow;

  rgb_frame_ctrl #(
    .DATA_SIZE(DW),
    .MAX_LEDS (ML),
    .CNT_W    (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_enable       (in_enable),
    .in_rd_fifo_empty(in_rd_fifo_empty),
    .in_rd_fifo_data (in_rd_fifo_data),
    .out_rd_fifo_en  (out_rd_fifo_en),
    .out_word        (out_word),
    .out_valid       (out_valid),
    .in_ready        (in_ready),
    .out_frame_done  (out_frame_done),
    .out_led_count   (out_led_count),
    .out_frame_count (out_frame_count),
    .out_overflow    (out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [31:0] led;
    logic [31:0] fc;
    logic        mk;
  } exp_t;

  logic [31:0] fifo[$];
  exp_t        exp_q[$];
  exp_t        cur;
  bit          pend = 0;
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // FIFO model: data appears the cycle after the pop strobe
  always @(posedge clk) begin
    if (out_rd_fifo_en && fifo.size() > 0)
      in_rd_fifo_data <= fifo.pop_front();
    in_rd_fifo_empty <= (fifo.size() == 0);
  end

  // Monitor: word on accept, counters one cycle later
  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        pend = 0;
        chk("led_count", 32'(out_led_count), cur.led);
        chk("frame_count", 32'(out_frame_count), cur.fc);
        chk("frame_done", 32'(out_frame_done), 32'(cur.mk));
      end
      if (out_valid && in_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", out_word, 32'hDEADDEAD);
        end else begin
          cur = exp_q.pop_front();
          chk("out_word", out_word, cur.w);
          pend = 1;
        end
      end
      if (out_frame_done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fpush(input logic [31:0] w);
    fifo.push_back(w);
  endtask

  task automatic epush(input logic [31:0] w, input logic [31:0] led,
                       input logic [31:0] fc);
    exp_t e;
    e.w   = w;
    e.led = led;
    e.fc  = fc;
    e.mk  = (w[31:24] != 8'h00);
    exp_q.push_back(e);
  endtask

  task automatic word(input logic [31:0] w, input logic [31:0] led,
                      input logic [31:0] fc);
    fpush(w);
    epush(w, led, fc);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || pend) && k < 500) begin
      tick(1);
      k++;
    end
    chk("drain_done", 32'(exp_q.size() == 0 && !pend), 32'd1);
    tick(2);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!out_valid && k < 100) begin
      tick(1);
      k++;
    end
    chk("wait_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int en_cnt;
    int k;
    rst       = 1'b1;
    in_enable = 1'b0;
    in_ready  = 1'b0;
    tick(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_word", out_word, 32'd0);
    chk("rst_rd_en", 32'(out_rd_fifo_en), 32'd0);
    chk("rst_led", 32'(out_led_count), 32'd0);
    chk("rst_fc", 32'(out_frame_count), 32'd0);
    chk("rst_ovf", 32'(out_overflow), 32'd0);
    chk("rst_done", 32'(out_frame_done), 32'd0);
    rst       = 1'b0;
    in_enable = 1'b1;
    in_ready  = 1'b1;

    // two pixels then a marker
    word(32'h0011_2233, 1, 0);
    word(32'h0044_5566, 2, 0);
    word(32'hFF00_0000, 0, 1);
    drain();
    chk("ovf_clear", 32'(out_overflow), 32'd0);

    // downstream stall for 10 cycles
    in_ready = 1'b0;
    word(32'h00AB_CDEF, 1, 1);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_word", out_word, 32'h00AB_CDEF);
      chk("stall_led", 32'(out_led_count), 32'd0);
      tick(1);
    end
    in_ready = 1'b1;
    drain();

    // overflow: six pixels into a four-LED frame
    word(32'hFE00_0000, 0, 2);
    word(32'h0000_0010, 1, 2);
    word(32'h0000_0020, 2, 2);
    word(32'h0000_0030, 3, 2);
    word(32'h0000_0040, 4, 2);
    fpush(32'h0000_0050);
    fpush(32'h0000_0060);
    word(32'h0100_0000, 0, 3);
    drain();
    chk("ovf_set", 32'(out_overflow), 32'd1);
    chk("led_after_ovf", 32'(out_led_count), 32'd0);

    // enable dropped while the first word is being popped
    in_enable = 1'b0;
    fpush(32'h0000_0001);
    fpush(32'h0000_0002);
    epush(32'h0000_0001, 1, 3);
    tick(3);
    in_enable = 1'b1;
    k = 0;
    while (!out_rd_fifo_en && k < 20) begin
      tick(1);
      k++;
    end
    chk("pop_seen", 32'(out_rd_fifo_en), 32'd1);
    in_enable = 1'b0;
    drain();
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_rd_fifo_en) en_cnt++;
      tick(1);
    end
    chk("no_pop_disabled", 32'(en_cnt), 32'd0);
    chk("fifo_left", 32'(fifo.size()), 32'd1);
    epush(32'h0000_0002, 2, 3);
    in_enable = 1'b1;
    drain();
    chk("ovf_sticky", 32'(out_overflow), 32'd1);

    // reset while a word is offered
    in_ready = 1'b0;
    fpush(32'h0000_0003);
    wait_valid();
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_word", out_word, 32'd0);
    chk("midrst_led", 32'(out_led_count), 32'd0);
    chk("midrst_fc", 32'(out_frame_count), 32'd0);
    chk("midrst_ovf", 32'(out_overflow), 32'd0);
    chk("midrst_done", 32'(out_frame_done), 32'd0);
    chk("midrst_rd_en", 32'(out_rd_fifo_en), 32'd0);
    rst      = 1'b0;
    in_ready = 1'b1;
    word(32'h0000_0004, 1, 0);
    drain();

    chk("done_pulses", 32'(done_cnt), 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
